// File: rtl/up_mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package up_arb_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    ACC  = 3'd2,
    RD   = 3'd3,
    ACK  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/up_mem_arbiter_if.sv
// Requester handshakes plus the shared memory port, bundled for the arbiter.
interface up_mem_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, mem_re, busy, owner
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, mem_re, busy, owner
  );
endinterface

// File: rtl/up_mem_arbiter_rr.sv
// Round-robin decision unit with bounded lock bursts; state advances only on decide.
module up_arb_rr #(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock_win,
  input  logic decide,
  output logic winner
);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  logic       last_q, lock_q;
  logic [3:0] burst_q, burst_d;

  // Any grant that is not a locked continuation restarts the burst count.
  always_comb begin
    winner  = req1;
    burst_d = 4'd0;
    if (req0 && req1) begin
      if (lock_q && (burst_q < BMAX)) begin
        winner  = last_q;
        burst_d = burst_q + 4'd1;
      end else begin
        winner  = ~last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      burst_q <= 4'd0;
    end else if (decide) begin
      last_q  <= winner;
      lock_q  <= lock_win;
      burst_q <= burst_d;
    end
  end
endmodule

// File: rtl/up_mem_arbiter.sv
// Two-master 8-bit memory port arbiter: ADDR / ACC / RD / ACK sequencing per access.
// Optional per-requester ack counters are built when UP_ARB_STATS_EN is defined.
module up_mem_arbiter
  import up_arb_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  up_mem_arbiter_if.slave  bus
`ifdef UP_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [7:0]       stat0,
  output logic [7:0]       stat1
`endif
);

  arb_state_e    state_q, state_d;
  logic          owner_q, we_q, decide, win, win_lock;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;

  // Grants are gated by rst so a request can never be granted without capture.
  assign decide   = (state_q == IDLE) && (bus.req0 || bus.req1) && !rst;
  assign win_lock = win ? bus.lock1 : bus.lock0;

  up_arb_rr #(.BURST_MAX(BURST_MAX)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req0     (bus.req0),
    .req1     (bus.req1),
    .lock_win (win_lock),
    .decide   (decide),
    .winner   (win)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req0 || bus.req1) state_d = ADDR;
      ADDR:    state_d = ACC;
      ACC:     state_d = we_q ? ACK : RD;
      RD:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (decide) begin
        owner_q <= win;
        we_q    <= win ? bus.we1    : bus.we0;
        addr_q  <= win ? bus.addr1  : bus.addr0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == RD) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = decide && (win == REQ_CPU);
  assign bus.gnt1      = decide && (win == REQ_DBG);
  assign bus.ack0      = (state_q == ACK) && (owner_q == REQ_CPU);
  assign bus.ack1      = (state_q == ACK) && (owner_q == REQ_DBG);
  assign bus.mem_we    = (state_q == ACC) &&  we_q;
  assign bus.mem_re    = (state_q == ACC) && !we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

`ifdef UP_ARB_STATS_EN
  // Saturating completed-access counters; clear wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat0 <= 8'd0;
      stat1 <= 8'd0;
    end else if (state_q == ACK) begin
      if (owner_q == REQ_CPU && stat0 != 8'hFF) stat0 <= stat0 + 8'd1;
      if (owner_q == REQ_DBG && stat1 != 8'hFF) stat1 <= stat1 + 8'd1;
    end
  end
`endif

endmodule
